// File: rtl/midi_pkg.sv
// Shared MIDI constants and the pitch-wheel receiver state encoding.
package midi_pkg;

  localparam logic [3:0]  ST_PITCHBEND      = 4'hE;
  localparam logic [3:0]  ST_CC             = 4'hB;
  localparam logic [6:0]  CC_RESET_ALL      = 7'd121;
  localparam logic [13:0] PW_CENTER_DEFAULT = 14'h2000;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PW_LSB = 3'd1,
    PW_MSB = 3'd2,
    CC_NUM = 3'd3,
    CC_VAL = 3'd4,
    OTHER  = 3'd5
  } pw_state_e;

endpackage

// File: rtl/midi_byte_classify.sv
// Splits a raw MIDI byte into its four mutually exclusive byte classes.
module midi_byte_classify (
  input  logic [7:0] i_rx_byte,
  output logic       o_is_realtime,
  output logic       o_is_syscommon,
  output logic       o_is_chstatus,
  output logic       o_is_data
);

  always_comb begin
    o_is_data      = ~i_rx_byte[7];
    o_is_realtime  = (i_rx_byte[7:3] == 5'b11111);
    o_is_syscommon = (i_rx_byte[7:3] == 5'b11110);
    o_is_chstatus  = i_rx_byte[7] & (i_rx_byte[6:4] != 3'b111);
  end

endmodule

// File: rtl/midi_pitchwheel_rx.sv
// Pitch Bend decoder with running status; also re-centres the wheel on CC 121.
module midi_pitchwheel_rx
  import midi_pkg::*;
#(
  parameter logic [13:0] PW_CENTER = PW_CENTER_DEFAULT,
  parameter bit          OMNI      = 1'b0
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [7:0]  i_rx_byte,
  input  logic        i_rx_valid,
  input  logic [3:0]  i_midi_ch,
  output logic [13:0] o_pw,
  output logic        o_pw_stb
);

  pw_state_e   r_state;
  pw_state_e   w_state_next;
  logic [6:0]  r_lsb;
  logic        r_ccr;
  logic [13:0] r_pw;
  logic        r_pw_stb;

  logic w_is_realtime;
  logic w_is_syscommon;
  logic w_is_chstatus;
  logic w_is_data;
  logic w_match;
  logic w_data_acc;
  logic w_lsb_we;
  logic w_ccr_we;
  logic w_pw_we_bend;
  logic w_pw_we_reset;

  midi_byte_classify u_classify (
    .i_rx_byte      (i_rx_byte),
    .o_is_realtime  (w_is_realtime),
    .o_is_syscommon (w_is_syscommon),
    .o_is_chstatus  (w_is_chstatus),
    .o_is_data      (w_is_data)
  );

  // The match decision is taken once at the status byte and lives on in the state.
  assign w_match    = OMNI || (i_rx_byte[3:0] == i_midi_ch);
  assign w_data_acc = i_rx_valid && w_is_data;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (i_rx_valid && !w_is_realtime) begin
      if (w_is_syscommon) begin
        w_state_next = IDLE;
      end else if (w_is_chstatus) begin
        if (w_match && (i_rx_byte[7:4] == ST_PITCHBEND)) begin
          w_state_next = PW_LSB;
        end else if (w_match && (i_rx_byte[7:4] == ST_CC)) begin
          w_state_next = CC_NUM;
        end else begin
          w_state_next = OTHER;
        end
      end else if (w_is_data) begin
        unique case (r_state)
          PW_LSB:  w_state_next = PW_MSB;
          PW_MSB:  w_state_next = PW_LSB;
          CC_NUM:  w_state_next = CC_VAL;
          CC_VAL:  w_state_next = CC_NUM;
          default: w_state_next = r_state;
        endcase
      end
    end
  end

  always_comb begin
    w_lsb_we      = w_data_acc && (r_state == PW_LSB);
    w_ccr_we      = w_data_acc && (r_state == CC_NUM);
    w_pw_we_bend  = w_data_acc && (r_state == PW_MSB);
    w_pw_we_reset = w_data_acc && (r_state == CC_VAL) && r_ccr;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_lsb    <= 7'd0;
      r_ccr    <= 1'b0;
      r_pw     <= PW_CENTER;
      r_pw_stb <= 1'b0;
    end else begin
      if (w_lsb_we) begin
        r_lsb <= i_rx_byte[6:0];
      end
      if (w_ccr_we) begin
        r_ccr <= (i_rx_byte[6:0] == CC_RESET_ALL);
      end
      if (w_pw_we_bend) begin
        r_pw <= {i_rx_byte[6:0], r_lsb};
      end else if (w_pw_we_reset) begin
        r_pw <= PW_CENTER;
      end
      r_pw_stb <= w_pw_we_bend || w_pw_we_reset;
    end
  end

  assign o_pw     = r_pw;
  assign o_pw_stb = r_pw_stb;

endmodule

// File: tb/tb_midi_pitchwheel_rx.sv
// Directed vector table plus randomized byte stream against a message-level model.
module tb_midi_pitchwheel_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_byte = 8'h00;
  logic        rx_valid = 1'b0;
  logic [3:0]  midi_ch = 4'h0;
  logic [13:0] pw;
  logic        pw_stb;

  midi_pitchwheel_rx #(
    .PW_CENTER (14'h2000),
    .OMNI      (1'b0)
  ) dut (
    .i_clk      (clk),
    .i_reset    (rst),
    .i_rx_byte  (rx_byte),
    .i_rx_valid (rx_valid),
    .i_midi_ch  (midi_ch),
    .o_pw       (pw),
    .o_pw_stb   (pw_stb)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        v;
    logic [7:0]  b;
    logic [3:0]  ch;
    logic [13:0] pw;
    logic        stb;
  } vec_t;

  vec_t vecs[$];

  // Model: running-status kind (0 none, 1 bend, 2 controller, 3 other) plus collected data.
  int          m_kind;
  logic [6:0]  m_q[$];
  logic [13:0] m_pw;
  logic        m_stb;

  function automatic void model_reset();
    m_kind = 0;
    m_q.delete();
    m_pw  = 14'h2000;
    m_stb = 1'b0;
  endfunction

  function automatic void model_byte(input logic v, input logic [7:0] b, input logic [3:0] c);
    logic match;
    m_stb = 1'b0;
    if (!v || b >= 8'hF8) return;
    if (b >= 8'hF0) begin
      m_kind = 0;
      m_q.delete();
      return;
    end
    if (b >= 8'h80) begin
      match = (b[3:0] == c);
      m_q.delete();
      if (match && b[7:4] == 4'hE) m_kind = 1;
      else if (match && b[7:4] == 4'hB) m_kind = 2;
      else m_kind = 3;
      return;
    end
    if (m_kind != 1 && m_kind != 2) return;
    m_q.push_back(b[6:0]);
    if (m_q.size() == 2) begin
      if (m_kind == 1) begin
        m_pw  = {m_q[1], m_q[0]};
        m_stb = 1'b1;
      end else if (m_q[0] == 7'd121) begin
        m_pw  = 14'h2000;
        m_stb = 1'b1;
      end
      m_q.delete();
    end
  endfunction

  task automatic check(input string name, input logic [13:0] exp_pw, input logic exp_stb);
    n_tests++;
    if (pw !== exp_pw || pw_stb !== exp_stb) begin
      n_fail++;
      $display("FAIL %s: got pw=%h stb=%b, want pw=%h stb=%b", name, pw, pw_stb, exp_pw, exp_stb);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] b, input logic [3:0] c);
    @(negedge clk);
    rx_valid = v;
    rx_byte  = b;
    midi_ch  = c;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic v, input logic [7:0] b, input logic [3:0] c,
                     input logic [13:0] p, input logic s);
    vec_t t;
    t.v = v; t.b = b; t.ch = c; t.pw = p; t.stb = s;
    vecs.push_back(t);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rx_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("async_reset", 14'h2000, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [7:0] b;
    logic [3:0] c;
    logic       v;
    int         sel;

    // Channel 3 bend, centre then maximum
    add(1, 8'hE3, 3, 14'h2000, 0); add(1, 8'h00, 3, 14'h2000, 0); add(1, 8'h40, 3, 14'h2000, 1);
    add(1, 8'hE3, 3, 14'h2000, 0); add(1, 8'h7F, 3, 14'h2000, 0); add(1, 8'h7F, 3, 14'h3FFF, 1);
    add(0, 8'h00, 3, 14'h3FFF, 0);
    // Running status on channel 0
    add(1, 8'hE0, 0, 14'h3FFF, 0); add(1, 8'h00, 0, 14'h3FFF, 0); add(1, 8'h00, 0, 14'h0000, 1);
    add(1, 8'h12, 0, 14'h0000, 0); add(1, 8'h34, 0, 14'h1A12, 1);
    // Real-time bytes interleaved
    add(1, 8'hE0, 0, 14'h1A12, 0); add(1, 8'hF8, 0, 14'h1A12, 0); add(1, 8'h05, 0, 14'h1A12, 0);
    add(1, 8'hFE, 0, 14'h1A12, 0); add(1, 8'h10, 0, 14'h0805, 1);
    // Wrong channel, then abandon into OTHER
    add(1, 8'hE5, 2, 14'h0805, 0); add(1, 8'h11, 2, 14'h0805, 0); add(1, 8'h22, 2, 14'h0805, 0);
    add(1, 8'hE2, 2, 14'h0805, 0); add(1, 8'h11, 2, 14'h0805, 0); add(1, 8'h90, 2, 14'h0805, 0);
    add(1, 8'h3C, 2, 14'h0805, 0); add(1, 8'h40, 2, 14'h0805, 0); add(1, 8'h7F, 2, 14'h0805, 0);
    // CC 121 re-centres, CC 7 does not; running-status CC 121 strobes even when unchanged
    add(1, 8'hE0, 0, 14'h0805, 0); add(1, 8'h7F, 0, 14'h0805, 0); add(1, 8'h7F, 0, 14'h3FFF, 1);
    add(1, 8'hB0, 0, 14'h3FFF, 0); add(1, 8'h79, 0, 14'h3FFF, 0); add(1, 8'h00, 0, 14'h2000, 1);
    add(1, 8'hB0, 0, 14'h2000, 0); add(1, 8'h07, 0, 14'h2000, 0); add(1, 8'h64, 0, 14'h2000, 0);
    add(1, 8'h79, 0, 14'h2000, 0); add(1, 8'h05, 0, 14'h2000, 1);
    // System common clears running status; midi_ch change mid-message has no effect
    add(1, 8'hE0, 0, 14'h2000, 0); add(1, 8'h01, 0, 14'h2000, 0); add(1, 8'h02, 0, 14'h0101, 1);
    add(1, 8'hF0, 0, 14'h0101, 0); add(1, 8'h12, 0, 14'h0101, 0); add(1, 8'h34, 0, 14'h0101, 0);
    add(1, 8'hE0, 0, 14'h0101, 0); add(1, 8'h03, 9, 14'h0101, 0); add(1, 8'h04, 9, 14'h0203, 1);
    add(1, 8'hF7, 9, 14'h0203, 0); add(1, 8'h7F, 9, 14'h0203, 0);

    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      check("idle_after_reset", 14'h2000, 1'b0);
    end

    foreach (vecs[i]) begin
      drive(vecs[i].v, vecs[i].b, vecs[i].ch);
      check($sformatf("vec%0d", i), vecs[i].pw, vecs[i].stb);
    end

    // Reset between LSB and MSB discards the partial bend
    drive(1, 8'hE0, 0); drive(1, 8'h00, 0); drive(1, 8'h00, 0);
    check("pre_reset_zero", 14'h0000, 1'b1);
    drive(1, 8'hE0, 0); drive(1, 8'h55, 0);
    do_reset();
    drive(1, 8'h7F, 0);
    check("msb_after_reset", 14'h2000, 1'b0);
    drive(0, 8'h00, 0);
    check("hold_after_reset", 14'h2000, 1'b0);

    do_reset();
    c = 4'h6;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) c = 4'($urandom_range(0, 15));
      v   = ($urandom_range(0, 4) != 0);
      sel = int'($urandom_range(0, 9));
      case (sel)
        0: b = {4'hE, ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : c};
        1: b = {4'hB, ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : c};
        2: b = 8'($urandom_range(8'h80, 8'hEF));
        3: b = 8'($urandom_range(8'hF8, 8'hFF));
        4: b = 8'($urandom_range(8'hF0, 8'hF7));
        5: b = 8'h79;
        6: b = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'h7F;
        default: b = 8'($urandom_range(0, 127));
      endcase
      drive(v, b, c);
      model_byte(v, b, c);
      check("random", m_pw, m_stb);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/midi_pitchwheel_rx.md
Name: midi_pitchwheel_rx

Overview:
- Upstream neighbour of the pitch-wheel interpolator. Consumes the MIDI byte stream from the UART receiver.
- Decodes Pitch Bend messages for the selected channel, with running status and interleaved real-time bytes.
- Holds the current 14-bit unsigned wheel value that drives the interpolator's PW input.
- Also honours Reset All Controllers (CC 121) by re-centring the wheel.

Parameters:
- PW_CENTER, 14'h2000: wheel value after reset and after CC 121.
- OMNI, 0: when 1, ignore midi_ch and accept every channel.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- rx_byte  in  8  received MIDI byte, valid only when rx_valid=1
- rx_valid  in  1  one-cycle strobe per received byte; back-to-back strobes are legal
- midi_ch  in  4  receive channel, 0..15, latched at each status byte
- pw  out  14  current wheel value, unsigned, registered; feeds the interpolator's PW input
- pw_stb  out  1  one-cycle pulse when pw has been written, even if the value is unchanged

Behaviour:
- Reset: asserting reset forces pw=PW_CENTER, pw_stb=0, state=IDLE, and clears the latched channel and LSB regardless of the clock. This applies mid-message too; a partial message is discarded.
- Bytes are processed only on clk edges where rx_valid=1. With rx_valid=0, state and pw hold and pw_stb=0.
- Byte classes:
  - Real-time 0xF8-0xFF: ignored entirely. No state change, running status preserved.
  - System common/exclusive 0xF0-0xF7: clears running status, state goes to IDLE.
  - Channel status 0x80-0xEF: sets running status. midi_ch is latched here.
  - Data 0x00-0x7F: handled per state.
- Channel match on a status byte: OMNI=1, or status[3:0]==midi_ch.
- States and transitions:
  - IDLE: data bytes are ignored.
  - From any state, a matching 0xEn status goes to PW_LSB.
  - From any state, a matching 0xBn status goes to CC_NUM.
  - Any other channel status, or a non-matching channel, goes to OTHER.
  - PW_LSB: on a data byte, store lsb=byte[6:0], go to PW_MSB.
  - PW_MSB: on a data byte, pw<= {byte[6:0], lsb} and go to PW_LSB (running status).
  - CC_NUM: on a data byte, flag ccr = (byte==7'd121), go to CC_VAL.
  - CC_VAL: on a data byte, if ccr then pw<=PW_CENTER. Go to CC_NUM.
  - OTHER: data bytes are ignored. Stays in OTHER until the next status byte.
- A status byte arriving in PW_MSB or CC_VAL abandons the partial message and leaves pw unchanged.
- Latency: pw and pw_stb update on the clk edge that accepts the completing data byte. pw_stb is high for exactly that one cycle.
- A change on midi_ch between status bytes has no effect on the message in progress.
- Width rules: only bit[6:0] of data bytes is used. pw is the straight 14-bit concatenation; no sign conversion and no clamping. 0x0000 and 0x3FFF pass through unchanged.

Decomposition:
- Shared package midi_pkg holds:
  - status nibble constants: ST_PITCHBEND=4'hE, ST_CC=4'hB
  - CC_RESET_ALL=7'd121
  - PW_CENTER default 14'h2000
  - the state encoding: IDLE, PW_LSB, PW_MSB, CC_NUM, CC_VAL, OTHER
- One combinational sub-module, midi_byte_classify: rx_byte in; is_realtime, is_syscommon, is_chstatus, is_data out. The same sub-module is reused by the note and controller parsers.

Test Plan:
- Reset release, no bytes: pw=0x2000 and pw_stb=0 held for 100 cycles.
- midi_ch=3, send E3 00 40: pw=0x2000, one pw_stb. Then E3 7F 7F: pw=0x3FFF, one pw_stb on the cycle the final byte is accepted.
- Running status, midi_ch=0: E0 00 00 followed by 12 34. pw=0x0000, then pw=0x1A12, two pw_stb pulses total.
- Real-time interleave: E0 F8 05 FE 10. Result pw=0x0805; the F8 and FE bytes change nothing.
- Channel and abandon:
  - midi_ch=2, send E5 11 22: pw unchanged, no pw_stb.
  - Then E2 11 90 3C 40: the 90 abandons the message, pw unchanged, state is OTHER, and 3C 40 are ignored.
- CC reset: with pw=0x3FFF, send B0 79 00: pw=0x2000 with pw_stb. B0 07 64 leaves pw unchanged. Also assert reset between LSB and MSB: pw=0x2000 and the following MSB byte is ignored.
